// File: rtl/cpu_pkg.sv
// Shared definitions for the 32-bit datapath control: opcode map, sequencer states,
// the control-word layout and memory wait bounds.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7,  OP_ROL  = 5'd8,  OP_SHR  = 5'd9,  OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15, OP_MUL  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19, OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam int MEM_WAIT_MIN = 0;
  localparam int MEM_WAIT_MAX = 3;
  localparam int WAIT_W       = 2;

  typedef enum logic [5:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FWAIT, S_FETCH2, S_FETCH3, S_DECODE,
    S_ALU1, S_ALUR2, S_ALUI2, S_UN, S_WB, S_MD1, S_MD3, S_MD4,
    S_LD1, S_LD2, S_LD3, S_LD4, S_LD5, S_LD6, S_ST4, S_ST5,
    S_BR1, S_BR2, S_BR3, S_BR4, S_JR1, S_JAL1, S_IN, S_OUT,
    S_MFHI, S_MFLO, S_NOP, S_HALT
  } state_t;

  typedef struct packed {
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Mem_read, Mem_write, IncPC;
    logic [4:0] opcode;
  } ctrl_t;

  // First execute state for an opcode; unassigned opcodes fall through to the idle step.
  function automatic state_t exec_entry(input logic [4:0] op);
    state_t s;
    case (op) inside
      OP_LD, OP_LDI, OP_ST: s = S_LD1;
      [OP_ADD:OP_ORI]:      s = S_ALU1;
      OP_DIV, OP_MUL:       s = S_MD1;
      OP_NEG, OP_NOT:       s = S_UN;
      OP_BR:                s = S_BR1;
      OP_JR:                s = S_JR1;
      OP_JAL:               s = S_JAL1;
      OP_IN:                s = S_IN;
      OP_OUT:               s = S_OUT;
      OP_MFHI:              s = S_MFHI;
      OP_MFLO:              s = S_MFLO;
      OP_HALT:              s = S_HALT;
      default:              s = S_NOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable down-counter for memory wait states; done while the count is zero.
module seq_wait_counter
  import cpu_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_clear_n,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_done
);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n)                       r_count <= '0;
    else if (i_load)                      r_count <= i_load_val;
    else if (i_dec && (r_count != '0))    r_count <= r_count - 1'b1;
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the 32-bit datapath control lines.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff_bit,
  output logic        IRin,
  output logic        PCin,
  output logic        RYin,
  output logic        RZin,
  output logic        MARin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        Outport_in,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhi_out,
  output logic        Zlo_out,
  output logic        PCout,
  output logic        MDRout,
  output logic        Inport_out,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic        IncPC,
  output logic [4:0]  opcode,
  output logic        run,
  output logic [5:0]  state_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

  state_t     r_state, w_next;
  logic       r_cond;
  ctrl_t      w_ctrl;
  logic [4:0] w_op;
  logic       w_load, w_dec, w_done;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RESET;
      r_cond  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_BR1) r_cond <= con_ff_bit;
    end
  end

  // Counter reloads on entry to a memory step; ST5 and LD4 loop on themselves until done.
  assign w_load = ((w_next == S_FETCH1) || (w_next == S_LD4) || (w_next == S_ST5)) &&
                  (w_next != r_state);
  assign w_dec  = (r_state == S_FETCH1) || (r_state == S_FWAIT) ||
                  (r_state == S_LD4)    || (r_state == S_ST5);

  seq_wait_counter u_wait (
    .i_clock    (clock),
    .i_clear_n  (clear),
    .i_load     (w_load),
    .i_load_val (WAIT_LOAD),
    .i_dec      (w_dec),
    .o_done     (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:  w_next = S_FETCH0;
      S_FETCH0: w_next = stop ? S_HALT : S_FETCH1;
      S_FETCH1: w_next = w_done ? S_FETCH2 : S_FWAIT;
      S_FWAIT:  if (w_done) w_next = S_FETCH2;
      S_FETCH2: w_next = S_FETCH3;
      S_FETCH3: w_next = S_DECODE;
      S_DECODE: w_next = exec_entry(w_op);
      S_ALU1:   w_next = (w_op inside {[OP_ADDI:OP_ORI]}) ? S_ALUI2 : S_ALUR2;
      S_ALUR2,
      S_ALUI2:  w_next = S_WB;
      S_UN:     w_next = ((w_op == OP_MUL) || (w_op == OP_DIV)) ? S_MD3 : S_WB;
      S_MD1:    w_next = S_UN;
      S_MD3:    w_next = S_MD4;
      S_LD1:    w_next = S_LD2;
      S_LD2:    w_next = S_LD3;
      S_LD3: begin
        if (w_op == OP_ST)       w_next = S_ST4;
        else if (w_op == OP_LDI) w_next = S_WB;
        else                     w_next = S_LD4;
      end
      S_LD4:    if (w_done) w_next = S_LD5;
      S_LD5:    w_next = S_LD6;
      S_ST4:    w_next = S_ST5;
      S_ST5:    if (w_done) w_next = S_FETCH0;
      S_BR1:    w_next = S_BR2;
      S_BR2:    w_next = S_BR3;
      S_BR3:    w_next = S_BR4;
      S_JAL1:   w_next = S_JR1;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH0;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH0: if (!stop) begin
        w_ctrl.PCout = 1'b1; w_ctrl.MARin = 1'b1; w_ctrl.IncPC = 1'b1; w_ctrl.RZin = 1'b1;
      end
      S_FETCH1: begin w_ctrl.Zlo_out = 1'b1; w_ctrl.PCin = 1'b1; w_ctrl.Mem_read = 1'b1; end
      S_FWAIT, S_LD4: w_ctrl.Mem_read = 1'b1;
      S_FETCH2, S_LD5: begin w_ctrl.Mem_read = 1'b1; w_ctrl.MDRin = 1'b1; end
      S_FETCH3: begin w_ctrl.MDRout = 1'b1; w_ctrl.IRin = 1'b1; end
      S_ALU1:   begin w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1; end
      S_ALUR2: begin
        w_ctrl.Grc = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RZin = 1'b1; w_ctrl.opcode = w_op;
      end
      S_ALUI2:  begin w_ctrl.Cout = 1'b1; w_ctrl.RZin = 1'b1; w_ctrl.opcode = w_op; end
      S_UN: begin
        w_ctrl.Grb = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RZin = 1'b1; w_ctrl.opcode = w_op;
      end
      S_WB:     begin w_ctrl.Zlo_out = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
      S_MD1:    begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.RYin = 1'b1; end
      S_MD3:    begin w_ctrl.Zlo_out = 1'b1; w_ctrl.LOin = 1'b1; end
      S_MD4:    begin w_ctrl.Zhi_out = 1'b1; w_ctrl.HIin = 1'b1; end
      S_LD1:    begin w_ctrl.Grb = 1'b1; w_ctrl.BAout = 1'b1; w_ctrl.RYin = 1'b1; end
      S_LD2, S_BR3: begin w_ctrl.Cout = 1'b1; w_ctrl.RZin = 1'b1; w_ctrl.opcode = OP_ADD; end
      S_LD3:    begin w_ctrl.Zlo_out = 1'b1; w_ctrl.MARin = 1'b1; end
      S_LD6:    begin w_ctrl.MDRout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
      S_ST4:    begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.MDRin = 1'b1; end
      S_ST5:    w_ctrl.Mem_write = 1'b1;
      S_BR1:    begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; end
      S_BR2:    begin w_ctrl.PCout = 1'b1; w_ctrl.RYin = 1'b1; end
      S_BR4:    if (r_cond) begin w_ctrl.Zlo_out = 1'b1; w_ctrl.PCin = 1'b1; end
      S_JR1:    begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.PCin = 1'b1; end
      S_JAL1:   begin w_ctrl.PCout = 1'b1; w_ctrl.Grb = 1'b1; w_ctrl.Rin = 1'b1; end
      S_IN:     begin w_ctrl.Inport_out = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
      S_OUT:    begin w_ctrl.Gra = 1'b1; w_ctrl.Rout = 1'b1; w_ctrl.Outport_in = 1'b1; end
      S_MFHI:   begin w_ctrl.HIout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
      S_MFLO:   begin w_ctrl.LOout = 1'b1; w_ctrl.Gra = 1'b1; w_ctrl.Rin = 1'b1; end
      default:  w_ctrl = '0;
    endcase
  end

  assign {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in,
          HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
          Gra, Grb, Grc, Rin, Rout, BAout, Mem_read, Mem_write, IncPC, opcode} = w_ctrl;

  assign run       = (r_state != S_RESET) && (r_state != S_HALT);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: three sequencers (MEM_WAIT 0,1,2) exercised one at a time against
// a per-instruction expected control-word list built from the opcode step tables.
module tb_control_sequencer;

  localparam int NI = 3;

  typedef struct packed {
    logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in;
    logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Mem_read, Mem_write, IncPC;
    logic [4:0] opcode;
    logic run;
  } cw_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [NI-1:0] clear_v;
  logic          stop, con;
  logic [31:0]   ir;
  logic [NI-1:0] IRin_v, PCin_v, RYin_v, RZin_v, MARin_v, MDRin_v, HIin_v, LOin_v, Outp_v;
  logic [NI-1:0] HIout_v, LOout_v, Zhi_v, Zlo_v, PCout_v, MDRout_v, Inp_v, Cout_v;
  logic [NI-1:0] Gra_v, Grb_v, Grc_v, Rin_v, Rout_v, BAout_v, Mrd_v, Mwr_v, IncPC_v, run_v;
  logic [4:0]    opc_v [NI];
  logic [5:0]    st_v  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    control_sequencer #(.MEM_WAIT(g)) u_dut (
      .clock(clock), .clear(clear_v[g]), .stop(stop), .ir(ir), .con_ff_bit(con),
      .IRin(IRin_v[g]), .PCin(PCin_v[g]), .RYin(RYin_v[g]), .RZin(RZin_v[g]),
      .MARin(MARin_v[g]), .MDRin(MDRin_v[g]), .HIin(HIin_v[g]), .LOin(LOin_v[g]),
      .Outport_in(Outp_v[g]), .HIout(HIout_v[g]), .LOout(LOout_v[g]), .Zhi_out(Zhi_v[g]),
      .Zlo_out(Zlo_v[g]), .PCout(PCout_v[g]), .MDRout(MDRout_v[g]), .Inport_out(Inp_v[g]),
      .Cout(Cout_v[g]), .Gra(Gra_v[g]), .Grb(Grb_v[g]), .Grc(Grc_v[g]), .Rin(Rin_v[g]),
      .Rout(Rout_v[g]), .BAout(BAout_v[g]), .Mem_read(Mrd_v[g]), .Mem_write(Mwr_v[g]),
      .IncPC(IncPC_v[g]), .opcode(opc_v[g]), .run(run_v[g]), .state_dbg(st_v[g])
    );
  end

  int  sel;
  cw_t obs;
  always_comb begin
    obs = '0;
    obs.IRin = IRin_v[sel]; obs.PCin = PCin_v[sel]; obs.RYin = RYin_v[sel];
    obs.RZin = RZin_v[sel]; obs.MARin = MARin_v[sel]; obs.MDRin = MDRin_v[sel];
    obs.HIin = HIin_v[sel]; obs.LOin = LOin_v[sel]; obs.Outport_in = Outp_v[sel];
    obs.HIout = HIout_v[sel]; obs.LOout = LOout_v[sel]; obs.Zhi_out = Zhi_v[sel];
    obs.Zlo_out = Zlo_v[sel]; obs.PCout = PCout_v[sel]; obs.MDRout = MDRout_v[sel];
    obs.Inport_out = Inp_v[sel]; obs.Cout = Cout_v[sel]; obs.Gra = Gra_v[sel];
    obs.Grb = Grb_v[sel]; obs.Grc = Grc_v[sel]; obs.Rin = Rin_v[sel]; obs.Rout = Rout_v[sel];
    obs.BAout = BAout_v[sel]; obs.Mem_read = Mrd_v[sel]; obs.Mem_write = Mwr_v[sel];
    obs.IncPC = IncPC_v[sel]; obs.opcode = opc_v[sel]; obs.run = run_v[sel];
  end

  int   checks, errors;
  cw_t  q[$];
  int   br_at;
  logic [4:0] op;
  logic c;
  int   wi;

  task automatic chk(input string tag, input cw_t o, input cw_t e);
    int drivers;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h want %h (state_dbg %0d)", tag, o, e, st_v[sel]);
    end
    drivers = int'(o.HIout) + int'(o.LOout) + int'(o.Zhi_out) + int'(o.Zlo_out) +
              int'(o.PCout) + int'(o.MDRout) + int'(o.Inport_out) + int'(o.Cout);
    checks++;
    assert (drivers <= 1) else begin
      errors++;
      $error("FAIL %s bus: got %0d drivers want at most 1", tag, drivers);
    end
  endtask

  function automatic cw_t z();
    cw_t w = '0;
    w.run = 1'b1;
    return w;
  endfunction

  // Expected control word per cycle for one instruction, starting at FETCH0.
  task automatic build(input logic [4:0] opc, input int mw, input logic cnd);
    cw_t w;
    int  o;
    o = int'(opc);
    q.delete(); br_at = -1;
    w = z(); w.PCout = 1; w.MARin = 1; w.IncPC = 1; w.RZin = 1; q.push_back(w);
    w = z(); w.Zlo_out = 1; w.PCin = 1; w.Mem_read = 1; q.push_back(w);
    repeat (mw) begin w = z(); w.Mem_read = 1; q.push_back(w); end
    w = z(); w.Mem_read = 1; w.MDRin = 1; q.push_back(w);
    w = z(); w.MDRout = 1; w.IRin = 1; q.push_back(w);
    q.push_back(z());
    if (o >= 3 && o <= 14) begin
      w = z(); w.Grb = 1; w.Rout = 1; w.RYin = 1; q.push_back(w);
      w = z(); if (o <= 11) begin w.Grc = 1; w.Rout = 1; end else w.Cout = 1;
      w.opcode = opc; w.RZin = 1; q.push_back(w);
      w = z(); w.Zlo_out = 1; w.Gra = 1; w.Rin = 1; q.push_back(w);
    end else if (o == 15 || o == 16) begin
      w = z(); w.Gra = 1; w.Rout = 1; w.RYin = 1; q.push_back(w);
      w = z(); w.Grb = 1; w.Rout = 1; w.opcode = opc; w.RZin = 1; q.push_back(w);
      w = z(); w.Zlo_out = 1; w.LOin = 1; q.push_back(w);
      w = z(); w.Zhi_out = 1; w.HIin = 1; q.push_back(w);
    end else if (o == 17 || o == 18) begin
      w = z(); w.Grb = 1; w.Rout = 1; w.opcode = opc; w.RZin = 1; q.push_back(w);
      w = z(); w.Zlo_out = 1; w.Gra = 1; w.Rin = 1; q.push_back(w);
    end else if (o <= 2) begin
      w = z(); w.Grb = 1; w.BAout = 1; w.RYin = 1; q.push_back(w);
      w = z(); w.Cout = 1; w.opcode = 5'd3; w.RZin = 1; q.push_back(w);
      w = z(); w.Zlo_out = 1; w.MARin = 1; q.push_back(w);
      if (o == 1) begin
        w = z(); w.Zlo_out = 1; w.Gra = 1; w.Rin = 1; q.push_back(w);
      end else if (o == 0) begin
        repeat (1 + mw) begin w = z(); w.Mem_read = 1; q.push_back(w); end
        w = z(); w.Mem_read = 1; w.MDRin = 1; q.push_back(w);
        w = z(); w.MDRout = 1; w.Gra = 1; w.Rin = 1; q.push_back(w);
      end else begin
        w = z(); w.Gra = 1; w.Rout = 1; w.MDRin = 1; q.push_back(w);
        repeat (1 + mw) begin w = z(); w.Mem_write = 1; q.push_back(w); end
      end
    end else begin
      case (o)
        19: begin
          br_at = q.size();
          w = z(); w.Gra = 1; w.Rout = 1; q.push_back(w);
          w = z(); w.PCout = 1; w.RYin = 1; q.push_back(w);
          w = z(); w.Cout = 1; w.opcode = 5'd3; w.RZin = 1; q.push_back(w);
          w = z(); if (cnd) begin w.Zlo_out = 1; w.PCin = 1; end q.push_back(w);
        end
        20: begin w = z(); w.Gra = 1; w.Rout = 1; w.PCin = 1; q.push_back(w); end
        21: begin
          w = z(); w.PCout = 1; w.Grb = 1; w.Rin = 1; q.push_back(w);
          w = z(); w.Gra = 1; w.Rout = 1; w.PCin = 1; q.push_back(w);
        end
        22: begin w = z(); w.Inport_out = 1; w.Gra = 1; w.Rin = 1; q.push_back(w); end
        23: begin w = z(); w.Gra = 1; w.Rout = 1; w.Outport_in = 1; q.push_back(w); end
        24: begin w = z(); w.HIout = 1; w.Gra = 1; w.Rin = 1; q.push_back(w); end
        25: begin w = z(); w.LOout = 1; w.Gra = 1; w.Rin = 1; q.push_back(w); end
        27: ;
        default: q.push_back(z());
      endcase
    end
  endtask

  // Entered #1 after the edge that starts step 0; leaves #1 after the edge ending step n-1.
  task automatic run_seq(input string name, input logic cnd, input int n);
    for (int k = 0; k < n; k++) begin
      stop = (k == 0) ? 1'b0 : 1'($urandom);
      con  = (k == br_at) ? cnd : 1'($urandom);
      @(negedge clock);
      chk($sformatf("%s mw%0d step%0d", name, sel, k), obs, q[k]);
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    clear_v = '0; stop = 1'b0;
    @(negedge clock);
    chk($sformatf("reset mw%0d", sel), obs, '0);
    clear_v[sel] = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    checks = 0; errors = 0; clear_v = '0; stop = 1'b0; con = 1'b0; ir = '0; sel = 0;
    repeat (2) @(posedge clock);
    for (int s = 0; s < NI; s++) begin
      sel = s;
      do_reset();
      ir = {5'd3, 4'd1, 4'd2, 4'd3, 15'd0};   // add R1,R2,R3
      build(5'd3, s, 1'b0); run_seq("add", 1'b0, q.size());
      ir = {5'd0, 4'd1, 4'd2, 19'h65};        // ld R1,0x65(R2)
      build(5'd0, s, 1'b0); run_seq("ld", 1'b0, q.size());
      ir = {5'd19, 27'h0};
      build(5'd19, s, 1'b0); run_seq("br0", 1'b0, q.size());
      build(5'd19, s, 1'b1); run_seq("br1", 1'b1, q.size());
      repeat (25) begin
        op = 5'($urandom_range(0, 31));
        if (op == 5'd27) op = 5'd26;
        c  = 1'($urandom);
        ir = {op, 27'($urandom)};
        build(op, s, c); run_seq($sformatf("rnd op%0d", op), c, q.size());
      end
      // st, then clear dropped in the middle of the first Mem_write cycle
      ir = {5'd2, 27'($urandom)};
      build(5'd2, s, 1'b0);
      wi = 0;
      while (!q[wi].Mem_write) wi++;
      run_seq("st", 1'b0, wi);
      stop = 1'b0;
      @(negedge clock);
      chk($sformatf("st mw%0d write", sel), obs, q[wi]);
      #2 clear_v[sel] = 1'b0;
      #1 chk($sformatf("st mw%0d async clear", sel), obs, '0);
      @(negedge clock); clear_v[sel] = 1'b1;
      @(posedge clock); #1;
      ir = {5'd31, 27'($urandom)};
      build(5'd31, s, 1'b0); run_seq("op31", 1'b0, q.size());
      // stop at FETCH0 parks the sequencer until reset
      stop = 1'b1;
      @(negedge clock);
      chk($sformatf("stop f0 mw%0d", sel), obs, z());
      @(posedge clock); #1;
      repeat (20) begin
        stop = 1'($urandom); ir = $urandom;
        @(negedge clock);
        chk($sformatf("halted mw%0d", sel), obs, '0);
        @(posedge clock); #1;
      end
      do_reset();
      ir = {5'd25, 27'($urandom)};
      build(5'd25, s, 1'b0); run_seq("mflo", 1'b0, q.size());
      ir = {5'd27, 27'($urandom)};
      build(5'd27, s, 1'b0); run_seq("halt", 1'b0, q.size());
      repeat (4) begin
        stop = 1'($urandom);
        @(negedge clock);
        chk($sformatf("halt op mw%0d", sel), obs, '0);
        @(posedge clock); #1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
